dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single 256-bit data memory between two cache-line requesters:
//  port 0 (instruction cache refill) and port 1 (data cache refill/write-back).
//  Sits between the cache controllers and the data memory.
//  Latches the granted request and holds it stable on the memory side until
//  mem_ack_i, then routes the ack back to the owner only.
//  Round-robin arbitration with a one-cycle turnaround between transactions.
// PARAMETERS
//  DATA_W      256  line width in bits (requester and memory data buses)
//  ADDR_W      32   byte address width
//  TIMEOUT_CYC 1023 GRANT cycles without ack before err_o sets (10-bit counter)
// PORTS
//  clk_i         in   1       clock, rising edge
//  rst_i         in   1       reset, asynchronous, active-low
//  r0_enable_i   in   1       port 0 request; level, held until r0_ack_o
//  r0_write_i    in   1       port 0: 1=write line, 0=read line
//  r0_addr_i     in   ADDR_W  port 0 line address ([4:0] ignored)
//  r0_data_i     in   DATA_W  port 0 write data
//  r0_data_o     out  DATA_W  port 0 read data; valid when r0_ack_o=1
//  r0_ack_o      out  1       port 0 completion, 1-cycle pulse
//  r1_*          -    -       port 1, same set and meaning as r0_*
//  mem_enable_o  out  1       memory request
//  mem_write_o   out  1       memory write strobe
//  mem_addr_o    out  ADDR_W  memory address, [4:0] forced to 0
//  mem_data_o    out  DATA_W  memory write data
//  mem_data_i    in   DATA_W  memory read data
//  mem_ack_i     in   1       memory completion
//  grant_o       out  2       one-hot owner, 00 when no owner
//  err_o         out  1       sticky timeout flag
// BEHAVIOUR
//  Reset (async, rst_i=0):
//   - state=IDLE, last=1 (port 0 wins the first tie).
//   - mem_enable_o, mem_write_o, grant_o, err_o, r*_ack_o are 0.
//   - mem_addr_o, mem_data_o, wait counter are 0.
//   - Reset mid-transaction abandons the transaction with no ack.
//  FSM IDLE -> GRANT -> RELEASE -> IDLE:
//   IDLE: no requester enabled -> stay.
//     One requester enabled -> it wins.
//     Both enabled -> the port != last wins.
//     At the edge: latch the winner's write/addr/data into the mem_* registers,
//     set mem_enable_o=1, grant_o=winner, last=winner, counter=0; go to GRANT.
//   GRANT: mem_* held from the latch; requester input changes are ignored.
//     mem_ack_i=1: rN_ack_o=1 for the owner this same cycle (combinational, gated
//     by grant). At the edge: mem_enable_o=0, mem_write_o=0, grant_o=00; go to RELEASE.
//     Else counter+1 (saturating). At counter==TIMEOUT_CYC, err_o<=1 (sticky
//     until reset) and the FSM keeps waiting.
//   RELEASE: one dead cycle; no grant; mem_ack_i ignored; go to IDLE.
//   Result: requesters see their registered enable update before rearbitration.
//  Latency: request seen at edge N -> mem_enable_o=1 from N+1.
//   Minimum spacing between transactions is ack cycle + 2.
//  rN_data_o = mem_data_i for both ports at all times; only the owner's ack qualifies it.
//  mem_ack_i in IDLE/RELEASE: ignored; no ack_o to either port.
//  Owner drops rN_enable_i during GRANT (protocol error): the transaction still
//   completes and the ack is still pulsed.
//  Back-to-back: an owner still enabled in IDLE (e.g. write-back followed by
//   refill) is regranted only if the other port is idle. Otherwise ports alternate.
//  Ack and a new request never collide: a grant is only issued from IDLE.
// TESTING
//  1 Single read: r1 read addr 0x0000_0420; mem acks after 3 cycles with line L
//    -> mem_addr_o=0x420 and mem_write_o=0 for 3 cycles; r1_ack_o pulses once
//    with r1_data_o=L; r0_ack_o stays 0.
//  2 Tie: r0 and r1 raised on the same edge after reset -> r0 granted first.
//    After ack + RELEASE -> r1 granted. With both still requesting -> r0 again.
//  3 Write latch: r1 write addr 0x1F80, data D; change r1_addr_i/r1_data_i during
//    GRANT -> mem_addr_o=0x1F80 and mem_data_o=D stay stable until ack.
//  4 Spurious ack: pulse mem_ack_i in IDLE and RELEASE -> no r*_ack_o,
//    grant_o=00, state unaffected.
//  5 Timeout: TIMEOUT_CYC=8, no ack -> err_o=1 after 8 GRANT cycles;
//    late ack -> completes normally, err_o stays 1 until reset.
//  6 Reset mid-GRANT: assert rst_i low -> mem_enable_o=0 immediately;
//    no ack produced; first request after release is granted normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one 256-bit data memory between
// the instruction-cache refill port (0) and the data-cache port (1).
module dmem_arbiter #(
   parameter int DATA_W      = 256,
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              r0_enable_i,
   input  logic              r0_write_i,
   input  logic [ADDR_W-1:0] r0_addr_i,
   input  logic [DATA_W-1:0] r0_data_i,
   output logic [DATA_W-1:0] r0_data_o,
   output logic              r0_ack_o,
   input  logic              r1_enable_i,
   input  logic              r1_write_i,
   input  logic [ADDR_W-1:0] r1_addr_i,
   input  logic [DATA_W-1:0] r1_data_i,
   output logic [DATA_W-1:0] r1_data_o,
   output logic              r1_ack_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic [DATA_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic [1:0]        grant_o,
   output logic              err_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_REL
   } state_e;

   localparam logic [9:0]        TO_CNT    = 10'(TIMEOUT_CYC);
   localparam logic [9:0]        CNT_MAX   = '1;
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(31);

   state_e              state_q, state_d;
   logic                last_q, last_d;
   logic [1:0]          grant_q, grant_d;
   logic                en_q, en_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [9:0]          cnt_q, cnt_d;
   logic [9:0]          cnt_inc;
   logic                err_q, err_d;
   logic                win_vld;
   logic                win;
   logic                in_grant;

   assign win_vld  = r0_enable_i | r1_enable_i;
   assign in_grant = (state_q == S_GRANT);
   assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 10'd1;

   // On a tie the port that did not win last time goes first.
   always_comb begin
      win = 1'b0;
      unique case ({r1_enable_i, r0_enable_i})
         2'b11:   win = ~last_q;
         2'b10:   win = 1'b1;
         default: win = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         last_q  <= 1'b1;
         grant_q <= 2'b00;
         en_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         en_q    <= en_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (win_vld) state_d = S_GRANT;
         S_GRANT: if (mem_ack_i) state_d = S_REL;
         S_REL:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      last_d  = last_q;
      grant_d = grant_q;
      en_d    = en_q;
      we_d    = we_q;
      addr_d  = addr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               last_d  = win;
               grant_d = win ? 2'b10 : 2'b01;
               en_d    = 1'b1;
               we_d    = win ? r1_write_i : r0_write_i;
               addr_d  = (win ? r1_addr_i : r0_addr_i) & LINE_MASK;
               data_d  = win ? r1_data_i : r0_data_i;
               cnt_d   = '0;
            end
         end
         S_GRANT: begin
            if (mem_ack_i) begin
               grant_d = 2'b00;
               en_d    = 1'b0;
               we_d    = 1'b0;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == TO_CNT) err_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign mem_enable_o = en_q;
   assign mem_write_o  = we_q;
   assign mem_addr_o   = addr_q;
   assign mem_data_o   = data_q;
   assign grant_o      = grant_q;
   assign err_o        = err_q;

   assign r0_data_o = mem_data_i;
   assign r1_data_o = mem_data_i;
   assign r0_ack_o  = mem_ack_i & in_grant & grant_q[0];
   assign r1_ack_o  = mem_ack_i & in_grant & grant_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a transaction-level model
// compared on every falling edge.
module tb_dmem_arbiter;

   localparam int DW = 256;
   localparam int AW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          r0_en = 0, r0_we = 0, r1_en = 0, r1_we = 0;
   logic [AW-1:0] r0_addr = '0, r1_addr = '0;
   logic [DW-1:0] r0_wd = '0, r1_wd = '0;
   logic [DW-1:0] r0_rd, r1_rd;
   logic          r0_ack, r1_ack;
   logic          m_en, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wd;
   logic [DW-1:0] m_rd = '0;
   logic          m_ack = 1'b0;
   logic [1:0]    gnt;
   logic          err;

   int n_vec = 0;
   int n_err = 0;
   bit run = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
      .clk_i(clk), .rst_i(rst_n),
      .r0_enable_i(r0_en), .r0_write_i(r0_we), .r0_addr_i(r0_addr),
      .r0_data_i(r0_wd), .r0_data_o(r0_rd), .r0_ack_o(r0_ack),
      .r1_enable_i(r1_en), .r1_write_i(r1_we), .r1_addr_i(r1_addr),
      .r1_data_i(r1_wd), .r1_data_o(r1_rd), .r1_ack_o(r1_ack),
      .mem_enable_o(m_en), .mem_write_o(m_we), .mem_addr_o(m_addr),
      .mem_data_o(m_wd), .mem_data_i(m_rd), .mem_ack_i(m_ack),
      .grant_o(gnt), .err_o(err)
   );

   task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
      end
   endtask

   // Model: who owns the memory, whether a dead cycle is pending, and
   // what was captured when the owner was chosen.
   int            own;
   bit            dead;
   int            last;
   bit            w_we;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_data;
   int            waited;
   bit            w_err;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         own = -1; dead = 0; last = 1; w_we = 0;
         w_addr = '0; w_data = '0; waited = 0; w_err = 0;
      end else if (own >= 0) begin
         if (m_ack) begin
            own = -1; dead = 1; w_we = 0;
         end else begin
            if (waited < 1023) waited++;
            if (waited == TO) w_err = 1;
         end
      end else if (dead) begin
         dead = 0;
      end else begin
         int w;
         w = -1;
         if (r0_en && r1_en) w = 1 - last;
         else if (r0_en) w = 0;
         else if (r1_en) w = 1;
         if (w >= 0) begin
            own = w; last = w; waited = 0;
            w_we   = (w == 1) ? r1_we : r0_we;
            w_addr = ((w == 1) ? r1_addr : r0_addr) & 32'hFFFF_FFE0;
            w_data = (w == 1) ? r1_wd : r0_wd;
         end
      end
   end

   always @(negedge clk) if (run) begin
      chk("mem_enable", DW'(m_en), DW'(own >= 0));
      chk("mem_write", DW'(m_we), DW'(w_we));
      chk("mem_addr", DW'(m_addr), DW'(w_addr));
      chk("mem_data", m_wd, w_data);
      chk("grant", DW'(gnt), DW'((own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00));
      chk("err", DW'(err), DW'(w_err));
      chk("r0_ack", DW'(r0_ack), DW'((own == 0) && m_ack));
      chk("r1_ack", DW'(r1_ack), DW'((own == 1) && m_ack));
      chk("r0_data", r0_rd, m_rd);
      chk("r1_data", r1_rd, m_rd);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic ack_now(logic [DW-1:0] line);
      m_ack = 1'b1;
      m_rd  = line;
      #1;
   endtask

   logic [DW-1:0] lineL, lineD;

   initial begin
      lineL = {8{32'hCAFE_0420}};
      lineD = {8{32'h1F80_D00D}};
      run = 1;
      #12;
      chk("rst_grant", DW'(gnt), DW'(2'b00));
      chk("rst_en", DW'(m_en), DW'(1'b0));
      chk("rst_err", DW'(err), DW'(1'b0));
      chk("rst_addr", DW'(m_addr), DW'(0));
      tick();
      rst_n = 1'b1;
      tick();

      // tie after reset: 0, then 1, then 0 again
      r0_en = 1; r0_addr = 32'h0000_1005; r0_wd = {8{32'h0000_0A0A}};
      r1_en = 1; r1_addr = 32'h0000_2000; r1_wd = {8{32'h0000_0B0B}};
      tick();
      chk("tie_first", DW'(gnt), DW'(2'b01));
      chk("tie_mask", DW'(m_addr), DW'(32'h1000));
      tick();
      ack_now({8{32'h1111_1111}});
      chk("tie_ack0", DW'(r0_ack), DW'(1'b1));
      chk("tie_noack1", DW'(r1_ack), DW'(1'b0));
      tick(); m_ack = 0;
      chk("tie_rel", DW'(gnt), DW'(2'b00));
      tick();
      tick();
      chk("tie_second", DW'(gnt), DW'(2'b10));
      ack_now({8{32'h2222_2222}});
      tick(); m_ack = 0;
      tick();
      tick();
      chk("tie_third", DW'(gnt), DW'(2'b01));
      ack_now({8{32'h3333_3333}});
      tick(); m_ack = 0; r0_en = 0; r1_en = 0;
      tick();
      tick();

      // single read on port 1
      r1_en = 1; r1_we = 0; r1_addr = 32'h0000_0420;
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("rd_addr", DW'(m_addr), DW'(32'h420));
         chk("rd_we", DW'(m_we), DW'(1'b0));
         if (i < 2) tick();
      end
      ack_now(lineL);
      chk("rd_ack1", DW'(r1_ack), DW'(1'b1));
      chk("rd_data1", r1_rd, lineL);
      chk("rd_ack0", DW'(r0_ack), DW'(1'b0));
      tick(); m_ack = 0; r1_en = 0;
      chk("rd_pulse", DW'(r1_ack), DW'(1'b0));
      tick();
      tick();

      // write latch: inputs change during the grant
      r1_en = 1; r1_we = 1; r1_addr = 32'h0000_1F80; r1_wd = lineD;
      tick();
      r1_addr = 32'h5555_5540; r1_wd = ~lineD; r1_we = 0;
      for (int i = 0; i < 3; i++) begin
         chk("wr_addr", DW'(m_addr), DW'(32'h1F80));
         chk("wr_data", m_wd, lineD);
         chk("wr_we", DW'(m_we), DW'(1'b1));
         tick();
      end
      ack_now('0);
      tick(); r1_en = 0;

      // spurious acks in release and idle
      chk("sp_rel_a0", DW'(r0_ack), DW'(1'b0));
      chk("sp_rel_a1", DW'(r1_ack), DW'(1'b0));
      tick();
      chk("sp_idle_a1", DW'(r1_ack), DW'(1'b0));
      chk("sp_idle_g", DW'(gnt), DW'(2'b00));
      tick(); m_ack = 0;

      // timeout then late ack
      r0_en = 1; r0_we = 0; r0_addr = 32'h0000_8000;
      tick();
      chk("to_grant", DW'(gnt), DW'(2'b01));
      for (int i = 0; i < 7; i++) tick();
      chk("to_before", DW'(err), DW'(1'b0));
      tick();
      chk("to_set", DW'(err), DW'(1'b1));
      tick();
      tick();
      ack_now({8{32'h7777_7777}});
      chk("to_late_ack", DW'(r0_ack), DW'(1'b1));
      tick(); m_ack = 0; r0_en = 0;
      tick();
      tick();
      chk("to_sticky", DW'(err), DW'(1'b1));

      // reset in the middle of a grant
      r1_en = 1; r1_we = 1; r1_addr = 32'h0000_0040;
      tick();
      chk("mr_grant", DW'(gnt), DW'(2'b10));
      rst_n = 0;
      m_ack = 1;
      #1;
      chk("mr_en", DW'(m_en), DW'(1'b0));
      chk("mr_noack", DW'(r1_ack), DW'(1'b0));
      chk("mr_err", DW'(err), DW'(1'b0));
      tick();
      tick();
      m_ack = 0;
      rst_n = 1;
      tick();
      chk("mr_regrant", DW'(gnt), DW'(2'b10));
      chk("mr_en2", DW'(m_en), DW'(1'b1));
      ack_now({8{32'h9999_9999}});
      chk("mr_ack", DW'(r1_ack), DW'(1'b1));
      tick(); m_ack = 0; r1_en = 0;
      tick();
      tick();

      run = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
